// File: rtl/seq_alu_pkg.sv
// Shared constants for seq_alu: opcodes, illegal-opcode boundary and FSM state encodings.
package seq_alu_pkg;

  localparam int unsigned OPW = 3;
  localparam int unsigned SW  = 2;

  localparam logic [OPW-1:0] OP_ADD         = 3'd0;
  localparam logic [OPW-1:0] OP_SUB         = 3'd1;
  localparam logic [OPW-1:0] OP_MUL         = 3'd2;
  localparam logic [OPW-1:0] OP_DIV         = 3'd3;
  localparam logic [OPW-1:0] OP_MOD         = 3'd4;
  localparam logic [OPW-1:0] OP_SQR         = 3'd5;
  localparam logic [OPW-1:0] OP_ILLEGAL_MIN = 3'd6;

  localparam logic [SW-1:0] S_IDLE = 2'd0;
  localparam logic [SW-1:0] S_DIV  = 2'd1;
  localparam logic [SW-1:0] S_HOLD = 2'd2;

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu; master drives operations, slave is the ALU.
interface seq_alu_if #(parameter int unsigned NBIT = 4);
  import seq_alu_pkg::*;

  localparam int unsigned RW = 2 * NBIT;

  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   result;
  logic            dz;
  logic            err;
  logic            sat;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, dz, err, sat
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, dz, err, sat
  );

endinterface

// File: rtl/seq_alu_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, NBIT cycles total.
// The first step is taken on the start cycle so done pulses NBIT-1 cycles after start.
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter int unsigned NBIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NBIT-1:0] dividend,
  input  logic [NBIT-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [NBIT-1:0] quotient,
  output logic [NBIT-1:0] remainder
);

  localparam int unsigned CW = $clog2(NBIT + 1);

  logic [NBIT-1:0] dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic [NBIT-1:0] src_rem_c;
  logic [NBIT-1:0] src_quo_c;
  logic [NBIT-1:0] src_dvsr_c;
  logic [NBIT:0]   part_c;
  logic [NBIT:0]   diff_c;
  logic            ge_c;

  // Step operands come straight from the inputs on the start cycle.
  always_comb begin
    src_rem_c  = start ? '0 : remainder;
    src_quo_c  = start ? dividend : quotient;
    src_dvsr_c = start ? divisor : dvsr_q;
    part_c     = {src_rem_c, src_quo_c[NBIT-1]};
    ge_c       = part_c >= {1'b0, src_dvsr_c};
    diff_c     = part_c - {1'b0, src_dvsr_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        remainder <= ge_c ? diff_c[NBIT-1:0] : part_c[NBIT-1:0];
        quotient  <= {src_quo_c[NBIT-2:0], ge_c};
      end
      if (start) begin
        dvsr_q <= divisor;
        cnt_q  <= CW'(NBIT - 1);
        busy   <= 1'b1;
      end else if (busy) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU (add/sub/mul/div/mod/sqr) with valid/ready in and out, one operation in flight.
// Define SEQ_ALU_SAT_EN to clamp ADD overflow / SUB underflow and report it on sat.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned NBIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);

  localparam int unsigned RW = 2 * NBIT;
  localparam int unsigned XW = NBIT + 1;

  logic [SW-1:0]   state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   result_q, result_d;
  logic            dz_q, dz_d;
  logic            err_q, err_d;
  logic            sat_q, sat_d;
  logic            is_mod_q, is_mod_d;
  logic            div_start_c;

  logic [XW-1:0]   sum_c;
  logic [XW-1:0]   diff_c;
  logic [RW-1:0]   prod_c;
  logic [RW-1:0]   sqr_c;

  logic            div_busy;
  logic            div_done;
  logic [NBIT-1:0] div_quo;
  logic [NBIT-1:0] div_rem;

  assign sum_c  = XW'(bus.a) + XW'(bus.b);
  assign diff_c = XW'(bus.a) - XW'(bus.b);
  assign prod_c = RW'(bus.a) * RW'(bus.b);
  assign sqr_c  = RW'(bus.a) * RW'(bus.a);

  seq_alu_div #(.NBIT(NBIT)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_c),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
      is_mod_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      is_mod_q    <= is_mod_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    dz_d        = dz_q;
    err_d       = err_q;
    sat_d       = sat_q;
    is_mod_d    = is_mod_q;
    div_start_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Every opcode except a real divide finishes here; the divide path overrides below.
          state_d     = S_HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          dz_d        = 1'b0;
          err_d       = 1'b0;
          sat_d       = 1'b0;
          result_d    = '0;
          case (bus.op)
            OP_ADD: begin
`ifdef SEQ_ALU_SAT_EN
              if (sum_c[NBIT]) begin
                result_d = RW'({NBIT{1'b1}});
                sat_d    = 1'b1;
              end else begin
                result_d = RW'(sum_c);
              end
`else
              result_d = RW'(sum_c);
`endif
            end
            OP_SUB: begin
`ifdef SEQ_ALU_SAT_EN
              if (diff_c[NBIT]) begin
                result_d = '0;
                sat_d    = 1'b1;
              end else begin
                result_d = RW'(diff_c);
              end
`else
              result_d = RW'(diff_c);
`endif
            end
            OP_MUL: result_d = prod_c;
            OP_SQR: result_d = sqr_c;
            OP_DIV, OP_MOD: begin
              is_mod_d = (bus.op == OP_MOD);
              if (bus.b == '0) begin
                result_d = (bus.op == OP_MOD) ? RW'(bus.a) : RW'({NBIT{1'b1}});
                dz_d     = 1'b1;
              end else begin
                state_d     = S_DIV;
                out_valid_d = 1'b0;
                div_start_c = 1'b1;
              end
            end
            default: err_d = is_illegal(bus.op);
          endcase
        end
      end

      S_DIV: begin
        if (div_done && !div_busy) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          result_d    = is_mod_q ? RW'(div_rem) : RW'(div_quo);
        end
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          result_d    = '0;
          dz_d        = 1'b0;
          err_d       = 1'b0;
          sat_d       = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.dz        = dz_q;
  assign bus.err       = err_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (NBIT=4) against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned NBIT = 4;
  localparam int unsigned RW   = 2 * NBIT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.NBIT(NBIT)) bus ();

  seq_alu #(.NBIT(NBIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit dz, output bit err,
                                output bit sat);
    int lim;
    int md;
    lim = (1 << NBIT) - 1;
    md  = 1 << (NBIT + 1);
    res = 0; dz = 0; err = 0; sat = 0;
    case (op)
      0: begin
        res = a + b;
`ifdef SEQ_ALU_SAT_EN
        if (res > lim) begin res = lim; sat = 1; end
`endif
      end
      1: begin
        res = (a - b + md) % md;
`ifdef SEQ_ALU_SAT_EN
        if (a < b) begin res = 0; sat = 1; end
`endif
      end
      2: res = a * b;
      3: if (b == 0) begin res = lim; dz = 1; end else res = a / b;
      4: if (b == 0) begin res = a;   dz = 1; end else res = a % b;
      5: res = a * a;
      default: err = 1;
    endcase
  endfunction

  function automatic int exp_latency(input int op, input int b);
    return ((op == 3 || op == 4) && b != 0) ? NBIT + 1 : 1;
  endfunction

  // Issue one op (called #1 after a rising edge with the DUT idle) and wait for its result.
  task automatic do_op(input int op, input int a, input int b,
                       output logic [RW-1:0] res, output logic dz, output logic err,
                       output logic sat, output int lat, output bit ready_low);
    bus.op       = 3'(op);
    bus.a        = NBIT'(a);
    bus.b        = NBIT'(b);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat       = 1;
    ready_low = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      if (bus.in_ready !== 1'b0) ready_low = 0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready !== 1'b0) ready_low = 0;
    res = bus.result;
    dz  = bus.dz;
    err = bus.err;
    sat = bus.sat;
  endtask

  task automatic take;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.result !== '0) $display("FAIL reset_result: got %0d want 0", bus.result); else passed++;
    checks++; if ({bus.dz, bus.err, bus.sat} !== 3'b000)
      $display("FAIL reset_flags: got dz/err/sat=%b want 000", {bus.dz, bus.err, bus.sat}); else passed++;
  endtask

  // Run one op fully and compare every observable against the model.
  task automatic run_and_check(input string tag, input int op, input int a, input int b);
    logic [RW-1:0] res;
    logic dz, err, sat;
    int lat, mres;
    bit ready_low, mdz, merr, msat;
    model(op, a, b, mres, mdz, merr, msat);
    do_op(op, a, b, res, dz, err, sat, lat, ready_low);
    checks++; if (res !== RW'(mres))
      $display("FAIL %s_result op=%0d a=%0d b=%0d: got %0d want %0d", tag, op, a, b, res, mres); else passed++;
    checks++; if ({dz, err, sat} !== {mdz, merr, msat})
      $display("FAIL %s_flags op=%0d a=%0d b=%0d: got dz/err/sat=%b want %b", tag, op, a, b,
               {dz, err, sat}, {mdz, merr, msat}); else passed++;
    checks++; if (lat !== exp_latency(op, b))
      $display("FAIL %s_latency op=%0d b=%0d: got %0d want %0d", tag, op, b, lat, exp_latency(op, b)); else passed++;
    checks++; if (!ready_low)
      $display("FAIL %s_in_ready_busy op=%0d: got 1 while busy want 0", tag, op); else passed++;
    take();
    checks++; if ({bus.out_valid, bus.in_ready, bus.err, bus.dz} !== 4'b0100)
      $display("FAIL %s_after_take: got valid/ready/err/dz=%b want 0100", tag,
               {bus.out_valid, bus.in_ready, bus.err, bus.dz}); else passed++;
  endtask

  task automatic test_directed;
    int vop[11] = '{0, 1, 2, 5, 3, 4, 3, 4, 6, 7, 0};
    int va[11]  = '{9, 3, 15, 13, 14, 14, 7, 7, 5, 1, 15};
    int vb[11]  = '{12, 5, 15, 0, 3, 3, 0, 0, 5, 2, 15};
    for (int i = 0; i < 11; i++) run_and_check("dir", vop[i], va[i], vb[i]);
  endtask

  task automatic test_literal;
    logic [RW-1:0] res;
    logic dz, err, sat;
    int lat;
    bit rl;
    do_op(0, 9, 12, res, dz, err, sat, lat, rl);
`ifdef SEQ_ALU_SAT_EN
    checks++; if ({res, sat} !== {8'd15, 1'b1}) $display("FAIL lit_add: got %0d sat=%b want 15 sat=1", res, sat); else passed++;
`else
    checks++; if ({res, sat} !== {8'd21, 1'b0}) $display("FAIL lit_add: got %0d sat=%b want 21 sat=0", res, sat); else passed++;
`endif
    take();
    do_op(3, 14, 3, res, dz, err, sat, lat, rl);
    checks++; if (res !== 8'd4 || lat !== 5) $display("FAIL lit_div: got %0d lat %0d want 4 lat 5", res, lat); else passed++;
    take();
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_and_check("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
  endtask

  task automatic test_backpressure;
    logic [RW-1:0] res;
    logic dz, err, sat;
    int lat, mres;
    bit rl, mdz, merr, msat;
    model(2, 11, 7, mres, mdz, merr, msat);
    do_op(2, 11, 7, res, dz, err, sat, lat, rl);
    for (int c = 0; c < 4; c++) begin
      bus.op = 3'd0; bus.a = NBIT'(c); bus.b = 4'd1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.result !== RW'(mres) || bus.err !== 1'b0)
        $display("FAIL bp_hold cyc=%0d: got valid/ready=%b result=%0d want 10 result=%0d", c,
                 {bus.out_valid, bus.in_ready}, bus.result, mres); else passed++;
    end
    bus.in_valid = 1'b0;
    take();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01)
        $display("FAIL bp_idle cyc=%0d: got valid/ready=%b want 01", c, {bus.out_valid, bus.in_ready}); else passed++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    bus.op = 3'd3; bus.a = 4'd13; bus.b = 4'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL rst_mid_div: got valid/ready=%b want 01", {bus.out_valid, bus.in_ready}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NBIT + 2; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0)
        $display("FAIL rst_discard cyc=%0d: got out_valid=%b want 0", c, bus.out_valid); else passed++;
    end
    run_and_check("post_rst", 4, 13, 4);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_literal();
    test_random();
    test_backpressure();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
